// File: rtl/qdec_pkg.sv
// Shared quadrature definitions: Gray state encodings, direction values and the
// transition classifier used by the decoder (and the matching encoder).
package qdec_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } qdec_state_e;

    typedef enum logic [1:0] {
        NONE,
        CW,
        CCW,
        ILLEGAL
    } qdec_move_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Clockwise successor in the 00->01->11->10 cycle.
    function automatic qdec_state_e qdec_cw_next(qdec_state_e s);
        qdec_state_e n;
        case (s)
            S00:     n = S01;
            S01:     n = S11;
            S11:     n = S10;
            default: n = S00;
        endcase
        return n;
    endfunction

    function automatic qdec_move_e qdec_classify(qdec_state_e prev, qdec_state_e cur);
        qdec_move_e m;
        if (cur == prev)                    m = NONE;
        else if (cur == qdec_cw_next(prev)) m = CW;
        else if (prev == qdec_cw_next(cur)) m = CCW;
        else                                m = ILLEGAL;
        return m;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder-pin and position/status bundle between the quadrature decoder and its user.
interface quadrature_decoder_if #(
    parameter int WIDTH = 16
);
    logic             a_in;
    logic             b_in;
    logic             clear;
    logic [WIDTH-1:0] pos;
    logic             step;
    logic             dir;
    logic             err;
    logic             err_sticky;

    modport master (
        output a_in, b_in, clear,
        input  pos, step, dir, err, err_sticky
    );

    modport slave (
        input  a_in, b_in, clear,
        output pos, step, dir, err, err_sticky
    );
endinterface

// File: rtl/qdec_input_cond.sv
// One quadrature channel: 2-FF synchronizer, plus a stability filter when
// QDEC_FILTER_EN is defined (level accepted after FILTER_LEN equal samples).
module qdec_input_cond
`ifdef QDEC_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    logic [1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], raw};
    end

`ifdef QDEC_FILTER_EN
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts consecutive samples disagreeing with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync_q[1] == level_q) begin
            cnt_q   <= '0;
        end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync_q[1];
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B receiver: step/dir pulses, wrapping signed position, illegal-jump flags.
// Optional input glitch filter enabled by defining QDEC_FILTER_EN.
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    quadrature_decoder_if.slave  bus
);

`ifdef QDEC_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // Priming waits until the synchronizer (and filter) hold real samples, so a level
    // held through reset is not decoded as a jump away from the reset value.
    localparam int WARMUP = 2 + (FILTER_EN ? FILTER_LEN : 0);
    localparam int WARM_W = $clog2(WARMUP + 1);

    logic a_lvl, b_lvl;

`ifdef QDEC_FILTER_EN
    qdec_input_cond #(.FILTER_LEN(FILTER_LEN)) u_cond_a (.clk(clk), .rst(rst), .raw(bus.a_in), .level(a_lvl));
    qdec_input_cond #(.FILTER_LEN(FILTER_LEN)) u_cond_b (.clk(clk), .rst(rst), .raw(bus.b_in), .level(b_lvl));
`else
    qdec_input_cond u_cond_a (.clk(clk), .rst(rst), .raw(bus.a_in), .level(a_lvl));
    qdec_input_cond u_cond_b (.clk(clk), .rst(rst), .raw(bus.b_in), .level(b_lvl));
`endif

    logic [WARM_W-1:0] warm_q;
    logic              primed_q;
    qdec_state_e       prev_q;
    logic [WIDTH-1:0]  pos_q;
    logic              step_q;
    logic              dir_q;
    logic              err_q;
    logic              err_sticky_q;

    qdec_state_e cur;
    qdec_move_e  move;
    logic        warm;
    logic        illegal_now;

    assign cur         = qdec_state_e'({a_lvl, b_lvl});
    assign move        = qdec_classify(prev_q, cur);
    assign warm        = (warm_q == WARM_W'(WARMUP));
    assign illegal_now = warm && primed_q && (move == ILLEGAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q       <= '0;
            primed_q     <= 1'b0;
            prev_q       <= S00;
            pos_q        <= '0;
            step_q       <= 1'b0;
            dir_q        <= DIR_CCW;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;

            if (!warm) begin
                warm_q <= warm_q + 1'b1;
            end else if (!primed_q) begin
                primed_q <= 1'b1;
                prev_q   <= cur;
            end else begin
                // prev follows the input even on an illegal jump so decoding resumes from it.
                prev_q <= cur;
                case (move)
                    CW: begin
                        step_q <= 1'b1;
                        dir_q  <= DIR_CW;
                        pos_q  <= pos_q + 1'b1;
                    end
                    CCW: begin
                        step_q <= 1'b1;
                        dir_q  <= DIR_CCW;
                        pos_q  <= pos_q - 1'b1;
                    end
                    ILLEGAL: err_q <= 1'b1;
                    default: ;
                endcase
            end

            // clear overrides the count; a same-cycle error still sets the sticky flag.
            if (bus.clear) pos_q <= '0;
            err_sticky_q <= (err_sticky_q & ~bus.clear) | illegal_now;
        end
    end

    assign bus.pos        = pos_q;
    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed self-checking bench for quadrature_decoder (16-bit and 4-bit instances
// sharing the same A/B/clear stimulus).
module tb_quadrature_decoder;

`ifdef QDEC_FILTER_EN
    localparam int PIPE = 6;
`else
    localparam int PIPE = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quadrature_decoder_if #(.WIDTH(16)) bus16 ();
    quadrature_decoder_if #(.WIDTH(4))  bus4  ();

    assign bus4.a_in  = bus16.a_in;
    assign bus4.b_in  = bus16.b_in;
    assign bus4.clear = bus16.clear;

    quadrature_decoder #(.WIDTH(16), .FILTER_LEN(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    quadrature_decoder #(.WIDTH(4),  .FILTER_LEN(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

    int total = 0;
    int bad   = 0;
    int n_step, n_cw, n_ccw, n_err;
    logic [1:0] ab;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus16.step) begin
                n_step++;
                if (bus16.dir) n_cw++;
                else           n_ccw++;
            end
            if (bus16.err) n_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cw_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive(input logic [1:0] s);
        ab         = s;
        bus16.a_in = s[1];
        bus16.b_in = s[0];
    endtask

    task automatic cw_step();
        drive(cw_next(ab));
        repeat (5) @(negedge clk);
    endtask

    task automatic ccw_step();
        drive(ccw_next(ab));
        repeat (5) @(negedge clk);
    endtask

    task automatic zero_counts();
        n_step = 0; n_cw = 0; n_ccw = 0; n_err = 0;
    endtask

    initial begin
        zero_counts();
        rst         = 1'b1;
        bus16.clear = 1'b0;
        drive(2'b00);
        repeat (3) @(negedge clk);

        check("rst_pos",        32'(bus16.pos),        32'h0);
        check("rst_step",       32'(bus16.step),       32'h0);
        check("rst_dir",        32'(bus16.dir),        32'h0);
        check("rst_err",        32'(bus16.err),        32'h0);
        check("rst_err_sticky", 32'(bus16.err_sticky), 32'h0);

        rst = 1'b0;
        repeat (PIPE + 4) @(negedge clk);
        check("prime_pos",   32'(bus16.pos), 32'h0);
        check("prime_steps", 32'(n_step),    32'h0);

        // Test 1: exact latency on first CW step, then seven more.
        drive(cw_next(ab));
        repeat (PIPE) @(negedge clk);
        check("lat_early_step", 32'(bus16.step), 32'h0);
        @(negedge clk);
        check("lat_step", 32'(bus16.step), 32'h1);
        check("lat_dir",  32'(bus16.dir),  32'h1);
        check("lat_pos",  32'(bus16.pos),  32'h1);
        @(negedge clk);
        check("lat_step_pulse", 32'(bus16.step), 32'h0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) cw_step();
        repeat (10) @(negedge clk);
        check("cw7_pos16", 32'(bus16.pos), 32'h7);
        check("cw7_pos4",  32'(bus4.pos),  32'h7);
        cw_step();
        repeat (10) @(negedge clk);
        check("cw8_steps",      32'(n_step),           32'd8);
        check("cw8_dir_cw",     32'(n_cw),             32'd8);
        check("cw8_pos16",      32'(bus16.pos),        32'h8);
        check("cw8_pos4_wrap",  32'(bus4.pos),         32'h8);
        check("cw8_err_sticky", 32'(bus16.err_sticky), 32'h0);

        // Test 2: 12 CCW steps from 8.
        zero_counts();
        for (int i = 0; i < 12; i++) ccw_step();
        repeat (10) @(negedge clk);
        check("ccw12_steps",    32'(n_step),    32'd12);
        check("ccw12_dir_ccw",  32'(n_ccw),     32'd12);
        check("ccw12_pos16",    32'(bus16.pos), 32'hFFFC);
        check("ccw12_pos4",     32'(bus4.pos),  32'hC);
        check("ccw12_dir_hold", 32'(bus16.dir), 32'h0);
        check("ccw12_no_err",   32'(n_err),     32'd0);

        // Test 4: illegal 00->11 jump, resume, clear.
        drive(2'b11);
        repeat (PIPE) @(negedge clk);
        check("ill_err_early", 32'(bus16.err), 32'h0);
        @(negedge clk);
        check("ill_err",        32'(bus16.err),        32'h1);
        check("ill_err_sticky", 32'(bus16.err_sticky), 32'h1);
        check("ill_no_step",    32'(bus16.step),       32'h0);
        check("ill_pos",        32'(bus16.pos),        32'hFFFC);
        @(negedge clk);
        check("ill_err_pulse",  32'(bus16.err),        32'h0);
        check("ill_sticky_hold",32'(bus16.err_sticky), 32'h1);
        repeat (6) @(negedge clk);
        cw_step();
        repeat (10) @(negedge clk);
        check("resume_pos", 32'(bus16.pos), 32'hFFFD);
        check("resume_dir", 32'(bus16.dir), 32'h1);
        bus16.clear = 1'b1;
        @(negedge clk);
        bus16.clear = 1'b0;
        check("clr_sticky", 32'(bus16.err_sticky), 32'h0);
        check("clr_pos16",  32'(bus16.pos),        32'h0);
        check("clr_pos4",   32'(bus4.pos),         32'h0);

        // clear in the same cycle as a step: clear wins on pos, step still reported.
        repeat (4) @(negedge clk);
        drive(cw_next(ab));
        repeat (PIPE) @(negedge clk);
        bus16.clear = 1'b1;
        @(negedge clk);
        bus16.clear = 1'b0;
        check("clr_step_step", 32'(bus16.step), 32'h1);
        check("clr_step_dir",  32'(bus16.dir),  32'h1);
        check("clr_step_pos",  32'(bus16.pos),  32'h0);

        // clear in the same cycle as an error: sticky set wins.
        repeat (4) @(negedge clk);
        drive(2'b11);
        repeat (PIPE) @(negedge clk);
        bus16.clear = 1'b1;
        @(negedge clk);
        bus16.clear = 1'b0;
        check("clr_err_err",    32'(bus16.err),        32'h1);
        check("clr_err_sticky", 32'(bus16.err_sticky), 32'h1);
        repeat (4) @(negedge clk);
        bus16.clear = 1'b1;
        @(negedge clk);
        bus16.clear = 1'b0;
        check("clr_err_release", 32'(bus16.err_sticky), 32'h0);

        // 0 - 1 wraps to all ones.
        repeat (4) @(negedge clk);
        ccw_step();
        repeat (10) @(negedge clk);
        check("wrap_down_pos16", 32'(bus16.pos), 32'hFFFF);
        check("wrap_down_pos4",  32'(bus4.pos),  32'hF);

        // Test 3: async reset mid-operation, A/B=11 held through release.
        rst = 1'b1;
        #1;
        check("async_rst_pos", 32'(bus16.pos), 32'h0);
        drive(2'b11);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        zero_counts();
        repeat (PIPE + 8) @(negedge clk);
        check("hold11_steps", 32'(n_step),    32'd0);
        check("hold11_errs",  32'(n_err),     32'd0);
        check("hold11_pos",   32'(bus16.pos), 32'h0);
        cw_step();
        repeat (10) @(negedge clk);
        check("hold11_then_cw_pos", 32'(bus16.pos), 32'h1);
        check("hold11_then_cw_dir", 32'(bus16.dir), 32'h1);

        // Short pulse on a_in (state 10 -> 00 for 2 cycles -> 10).
        drive(2'b00);
        repeat (2) @(negedge clk);
        drive(2'b10);
        repeat (12) @(negedge clk);
`ifdef QDEC_FILTER_EN
        check("glitch_steps", 32'(n_step),    32'd1);
        check("glitch_pos",   32'(bus16.pos), 32'h1);
        drive(2'b00);
        repeat (12) @(negedge clk);
        check("level_steps", 32'(n_step),    32'd2);
        check("level_pos",   32'(bus16.pos), 32'h2);
`else
        check("pulse_steps", 32'(n_step),    32'd3);
        check("pulse_pos",   32'(bus16.pos), 32'h1);
`endif
        check("final_errs", 32'(n_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
